// File: rtl/pcd8544_pkg.sv
// Shared definitions for the PCD8544 serial receiver: opcode masks, display modes and
// the controller register file layout.
package pcd8544_pkg;

   localparam int unsigned COLS_DEF = 84;
   localparam int unsigned ROWS_DEF = 6;

   localparam logic [7:0] FUNC_SET_MASK  = 8'hF8;
   localparam logic [7:0] FUNC_SET_VAL   = 8'h20;
   localparam logic [7:0] DISP_CTRL_MASK = 8'hFA;
   localparam logic [7:0] DISP_CTRL_VAL  = 8'h08;
   localparam logic [7:0] SET_Y_MASK     = 8'hF8;
   localparam logic [7:0] SET_Y_VAL      = 8'h40;
   localparam logic [7:0] SET_X_MASK     = 8'h80;
   localparam logic [7:0] SET_X_VAL      = 8'h80;
   localparam logic [7:0] TEMP_CTRL_MASK = 8'hFC;
   localparam logic [7:0] TEMP_CTRL_VAL  = 8'h04;
   localparam logic [7:0] BIAS_MASK      = 8'hF8;
   localparam logic [7:0] BIAS_VAL       = 8'h10;
   localparam logic [7:0] VOP_MASK       = 8'h80;
   localparam logic [7:0] VOP_VAL        = 8'h80;

   localparam logic [1:0] DISP_BLANK   = 2'b00;
   localparam logic [1:0] DISP_NORMAL  = 2'b10;
   localparam logic [1:0] DISP_ALL_ON  = 2'b01;
   localparam logic [1:0] DISP_INVERSE = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDecode
   } rx_state_e;

   typedef struct packed {
      logic       power_down;
      logic       v_addr;
      logic       ext_instr;
      logic [1:0] disp_mode;
      logic [6:0] vop;
      logic [2:0] bias;
      logic [1:0] tc;
      logic [6:0] x;
      logic [2:0] y;
   } ctrl_regs_t;

   localparam ctrl_regs_t CTRL_RESET = '{
      power_down: 1'b1,
      v_addr:     1'b0,
      ext_instr:  1'b0,
      disp_mode:  DISP_BLANK,
      vop:        7'd0,
      bias:       3'd0,
      tc:         2'd0,
      x:          7'd0,
      y:          3'd0
   };

   function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                     input logic [7:0] val);
      return (b & mask) == val;
   endfunction

endpackage

// File: rtl/pcd8544_spi_rx_spi_byte_deserializer.sv
// Synchronises the serial link pins, detects sclk rising edges and assembles MSB-first bytes.
module spi_byte_deserializer #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_sclk,
   input  logic       i_mosi,
   input  logic       i_sce,
   input  logic       i_dc,
   input  logic       i_lcd_rst,
   output logic       o_sce,
   output logic       o_lcd_rst_n,
   output logic       o_byte_stb,
   output logic [7:0] o_byte,
   output logic       o_dc
);

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_sce_sync;
   logic [SYNC_STAGES-1:0] r_dc_sync;
   logic [SYNC_STAGES-1:0] r_rst_sync;
   logic [6:0]             r_shift;
   logic [2:0]             r_cnt;

   logic w_rise;
   logic w_sce;
   logic w_lcd_rst_n;
   logic w_mosi;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_sce_sync  <= '1;
         r_dc_sync   <= '0;
         r_rst_sync  <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
         r_sce_sync  <= {r_sce_sync[SYNC_STAGES-2:0], i_sce};
         r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], i_dc};
         r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], i_lcd_rst};
      end
   end

   // Newer stage high while the oldest is still low marks a rising edge.
   assign w_rise      = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
   assign w_sce       = r_sce_sync[SYNC_STAGES-1];
   assign w_lcd_rst_n = r_rst_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (!w_lcd_rst_n || w_sce) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (w_rise) begin
         r_shift <= {r_shift[5:0], w_mosi};
         r_cnt   <= r_cnt + 3'd1;
      end
   end

   assign o_byte_stb  = w_rise & ~w_sce & w_lcd_rst_n & (r_cnt == 3'd7);
   assign o_byte      = {r_shift, w_mosi};
   assign o_dc        = r_dc_sync[SYNC_STAGES-1];
   assign o_sce       = w_sce;
   assign o_lcd_rst_n = w_lcd_rst_n;

endmodule

// File: rtl/pcd8544_spi_rx.sv
// PCD8544 device-side receiver: decodes serial bytes into controller registers and
// framebuffer writes.
module pcd8544_spi_rx
   import pcd8544_pkg::*;
#(
   parameter int unsigned COLS        = COLS_DEF,
   parameter int unsigned ROWS        = ROWS_DEF,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AW          = 9
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_sclk,
   input  logic          i_mosi,
   input  logic          i_sce,
   input  logic          i_dc,
   input  logic          i_lcd_rst,
   output logic          o_wr_en,
   output logic [AW-1:0] o_wr_addr,
   output logic [7:0]    o_wr_data,
   output logic          o_byte_valid,
   output logic          o_power_down,
   output logic          o_v_addr,
   output logic          o_ext_instr,
   output logic [1:0]    o_disp_mode,
   output logic [6:0]    o_vop,
   output logic [2:0]    o_bias,
   output logic [1:0]    o_tc
);

   logic       w_sce;
   logic       w_lcd_rst_n;
   logic       w_stb;
   logic [7:0] w_byte;
   logic       w_dc;

   spi_byte_deserializer #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_deser (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_sclk     (i_sclk),
      .i_mosi     (i_mosi),
      .i_sce      (i_sce),
      .i_dc       (i_dc),
      .i_lcd_rst  (i_lcd_rst),
      .o_sce      (w_sce),
      .o_lcd_rst_n(w_lcd_rst_n),
      .o_byte_stb (w_stb),
      .o_byte     (w_byte),
      .o_dc       (w_dc)
   );

   ctrl_regs_t    r_ctl;
   rx_state_e     r_state;
   logic          r_wr_en;
   logic [AW-1:0] r_wr_addr;
   logic [7:0]    r_wr_data;
   logic          r_bv;

   logic [AW-1:0] w_addr;
   logic          w_last_x;
   logic          w_last_y;

   assign w_addr   = AW'(r_ctl.y) * AW'(COLS) + AW'(r_ctl.x);
   assign w_last_x = (r_ctl.x == 7'(COLS - 1));
   assign w_last_y = (r_ctl.y == 3'(ROWS - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ctl     <= CTRL_RESET;
         r_state   <= StIdle;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_bv      <= 1'b0;
      end else if (!w_lcd_rst_n) begin
         r_ctl     <= CTRL_RESET;
         r_state   <= StIdle;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_bv      <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_bv    <= 1'b0;

         case (r_state)
            StIdle:   r_state <= w_sce ? StIdle : StShift;
            StShift:  r_state <= w_sce ? StIdle : StShift;
            StDecode: r_state <= w_sce ? StIdle : StShift;
            default:  r_state <= StIdle;
         endcase

         if (w_stb) begin
            r_state <= StDecode;
            r_bv    <= 1'b1;
            if (w_dc) begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= w_addr;
               r_wr_data <= w_byte;
               // The last cell wraps to (0,0) in both addressing modes.
               if (!r_ctl.v_addr) begin
                  if (w_last_x) begin
                     r_ctl.x <= '0;
                     r_ctl.y <= w_last_y ? 3'd0 : r_ctl.y + 3'd1;
                  end else begin
                     r_ctl.x <= r_ctl.x + 7'd1;
                  end
               end else begin
                  if (w_last_y) begin
                     r_ctl.y <= '0;
                     r_ctl.x <= w_last_x ? 7'd0 : r_ctl.x + 7'd1;
                  end else begin
                     r_ctl.y <= r_ctl.y + 3'd1;
                  end
               end
            end else if (w_byte == 8'h00) begin
               r_ctl <= r_ctl;
            end else if (op_match(w_byte, FUNC_SET_MASK, FUNC_SET_VAL)) begin
               r_ctl.power_down <= w_byte[2];
               r_ctl.v_addr     <= w_byte[1];
               r_ctl.ext_instr  <= w_byte[0];
            end else if (!r_ctl.ext_instr) begin
               if (op_match(w_byte, DISP_CTRL_MASK, DISP_CTRL_VAL)) begin
                  r_ctl.disp_mode <= {w_byte[2], w_byte[0]};
               end else if (op_match(w_byte, SET_Y_MASK, SET_Y_VAL)) begin
                  if (32'(w_byte[2:0]) < ROWS) r_ctl.y <= w_byte[2:0];
               end else if (op_match(w_byte, SET_X_MASK, SET_X_VAL)) begin
                  if (32'(w_byte[6:0]) < COLS) r_ctl.x <= w_byte[6:0];
               end
            end else begin
               if (op_match(w_byte, TEMP_CTRL_MASK, TEMP_CTRL_VAL)) begin
                  r_ctl.tc <= w_byte[1:0];
               end else if (op_match(w_byte, BIAS_MASK, BIAS_VAL)) begin
                  r_ctl.bias <= w_byte[2:0];
               end else if (op_match(w_byte, VOP_MASK, VOP_VAL)) begin
                  r_ctl.vop <= w_byte[6:0];
               end
            end
         end
      end
   end

   assign o_wr_en      = r_wr_en;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = r_wr_data;
   assign o_byte_valid = r_bv;
   assign o_power_down = r_ctl.power_down;
   assign o_v_addr     = r_ctl.v_addr;
   assign o_ext_instr  = r_ctl.ext_instr;
   assign o_disp_mode  = r_ctl.disp_mode;
   assign o_vop        = r_ctl.vop;
   assign o_bias       = r_ctl.bias;
   assign o_tc         = r_ctl.tc;

endmodule

// File: tb/tb_pcd8544_spi_rx.sv
// Bench for pcd8544_spi_rx: table-driven byte vectors with a write scoreboard, plus
// hand-written sequences for latency, aborted bytes and lcd_rst.
module tb_pcd8544_spi_rx;

   logic       clk;
   logic       rst_n;
   logic       sclk;
   logic       mosi;
   logic       sce;
   logic       dc;
   logic       lcd_rst;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic       byte_valid;
   logic       power_down;
   logic       v_addr;
   logic       ext_instr;
   logic [1:0] disp_mode;
   logic [6:0] vop;
   logic [2:0] bias;
   logic [1:0] tc;

   pcd8544_spi_rx #(
      .COLS       (84),
      .ROWS       (6),
      .SYNC_STAGES(2),
      .AW         (9)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_sclk      (sclk),
      .i_mosi      (mosi),
      .i_sce       (sce),
      .i_dc        (dc),
      .i_lcd_rst   (lcd_rst),
      .o_wr_en     (wr_en),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_byte_valid(byte_valid),
      .o_power_down(power_down),
      .o_v_addr    (v_addr),
      .o_ext_instr (ext_instr),
      .o_disp_mode (disp_mode),
      .o_vop       (vop),
      .o_bias      (bias),
      .o_tc        (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      logic       dc;
      logic       eog;
      logic       exp_wr;
      logic [8:0] exp_addr;
      logic       exp_h;
      logic       exp_v;
      logic [6:0] exp_vop;
   } vec_t;

   vec_t        vecs[$];
   logic [16:0] exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int exp_bv = 0;
   int n_rd = 0;

   // Written only by the monitor below.
   logic [8:0] obs_addr[64];
   logic [7:0] obs_data[64];
   int         n_wr = 0;
   int         n_bv = 0;

   always @(negedge clk) begin
      if (wr_en && n_wr < 64) begin
         obs_addr[n_wr] = wr_addr;
         obs_data[n_wr] = wr_data;
         n_wr = n_wr + 1;
      end
      if (byte_valid) n_bv = n_bv + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic spi_bit(input logic b, input logic d);
      #1;
      sclk = 1'b0;
      mosi = b;
      dc   = d;
      repeat (2) @(posedge clk);
      #1;
      sclk = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic d);
      for (int i = 7; i >= 0; i--) spi_bit(b[i], d);
   endtask

   task automatic drain_writes();
      logic [16:0] e;
      while (n_rd < n_wr) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h required none",
                     obs_addr[n_rd], obs_data[n_rd]);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(obs_addr[n_rd]), 32'(e[16:8]));
            check("wr_data", 32'(obs_data[n_rd]), 32'(e[7:0]));
         end
         n_rd++;
      end
   endtask

   task automatic check_reset_regs(input string tag);
      check({tag, "_power_down"}, 32'(power_down), 32'd1);
      check({tag, "_ext_instr"}, 32'(ext_instr), 32'd0);
      check({tag, "_v_addr"}, 32'(v_addr), 32'd0);
      check({tag, "_disp_mode"}, 32'(disp_mode), 32'd0);
      check({tag, "_vop"}, 32'(vop), 32'd0);
      check({tag, "_bias"}, 32'(bias), 32'd0);
      check({tag, "_tc"}, 32'(tc), 32'd0);
   endtask

   task automatic lower_sce();
      @(posedge clk);
      #1;
      sce = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic raise_sce();
      @(posedge clk);
      #1;
      sce = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      logic [7:0] b;

      // {byte, dc, end-of-group, expect write, addr, H after, V after, vop after}
      vecs.push_back('{8'h21, 1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 7'h00});
      vecs.push_back('{8'h90, 1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 7'h10});
      vecs.push_back('{8'h20, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h0C, 1'b0, 1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'hA1, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h42, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'hFE, 1'b1, 1'b0, 1'b1, 9'd201, 1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h81, 1'b1, 1'b1, 1'b1, 9'd202, 1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'hD3, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h45, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h55, 1'b1, 1'b0, 1'b1, 9'd503, 1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'hAA, 1'b1, 1'b1, 1'b1, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h22, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b1, 7'h10});
      vecs.push_back('{8'h80, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b1, 7'h10});
      vecs.push_back('{8'h45, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b1, 7'h10});
      vecs.push_back('{8'h11, 1'b1, 1'b0, 1'b1, 9'd420, 1'b0, 1'b1, 7'h10});
      vecs.push_back('{8'h22, 1'b1, 1'b1, 1'b1, 9'd1,   1'b0, 1'b1, 7'h10});
      vecs.push_back('{8'h20, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h8A, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h43, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'hD4, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h46, 1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h99, 1'b1, 1'b1, 1'b1, 9'd262, 1'b0, 1'b0, 7'h10});
      vecs.push_back('{8'h21, 1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 7'h10});
      vecs.push_back('{8'h14, 1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 7'h10});
      vecs.push_back('{8'h06, 1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 7'h10});
      vecs.push_back('{8'hC5, 1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 7'h45});
      vecs.push_back('{8'h20, 1'b0, 1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 7'h45});

      sclk    = 1'b0;
      mosi    = 1'b0;
      sce     = 1'b1;
      dc      = 1'b0;
      lcd_rst = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_regs("reset");
      check("reset_wr_en", 32'(wr_en), 32'd0);
      check("reset_byte_valid", 32'(byte_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      foreach (vecs[i]) begin
         if (sce) lower_sce();
         if (vecs[i].exp_wr) exp_q.push_back({vecs[i].exp_addr, vecs[i].b});
         exp_bv++;
         send_byte(vecs[i].b, vecs[i].dc);
         repeat (3) @(posedge clk);
         drain_writes();
         check("byte_valid_count", 32'(n_bv), 32'(exp_bv));
         check("ext_instr", 32'(ext_instr), 32'(vecs[i].exp_h));
         check("v_addr", 32'(v_addr), 32'(vecs[i].exp_v));
         check("vop", 32'(vop), 32'(vecs[i].exp_vop));
         if (vecs[i].eog) begin
            raise_sce();
            check("missing_writes", 32'(exp_q.size()), 32'd0);
         end
      end
      check("power_down", 32'(power_down), 32'd0);
      check("disp_mode", 32'(disp_mode), 32'b10);
      check("bias", 32'(bias), 32'd4);
      check("tc", 32'(tc), 32'd2);

      // Aborted partial byte, then a full data byte with exact output latency.
      lower_sce();
      spi_bit(1'b1, 1'b1);
      spi_bit(1'b0, 1'b1);
      spi_bit(1'b1, 1'b1);
      spi_bit(1'b1, 1'b1);
      spi_bit(1'b0, 1'b1);
      raise_sce();
      lower_sce();
      b = 8'h3C;
      exp_q.push_back({9'd263, b});
      exp_bv++;
      for (int i = 7; i >= 1; i--) spi_bit(b[i], 1'b1);
      #1;
      sclk = 1'b0;
      mosi = b[0];
      dc   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sclk = 1'b1;
      @(negedge clk);
      check("lat_bv_edge", 32'(byte_valid), 32'd0);
      @(negedge clk);
      check("lat_bv_detect", 32'(byte_valid), 32'd0);
      check("lat_wr_detect", 32'(wr_en), 32'd0);
      @(negedge clk);
      check("lat_bv_out", 32'(byte_valid), 32'd1);
      check("lat_wr_out", 32'(wr_en), 32'd1);
      @(negedge clk);
      check("lat_bv_pulse_end", 32'(byte_valid), 32'd0);
      check("lat_wr_pulse_end", 32'(wr_en), 32'd0);
      repeat (2) @(posedge clk);
      drain_writes();
      check("abort_bv_count", 32'(n_bv), 32'(exp_bv));
      check("abort_missing_writes", 32'(exp_q.size()), 32'd0);

      // lcd_rst mid-byte: registers return to reset values and the partial byte is lost.
      spi_bit(1'b1, 1'b1);
      spi_bit(1'b1, 1'b1);
      spi_bit(1'b0, 1'b1);
      spi_bit(1'b1, 1'b1);
      @(posedge clk);
      #1;
      lcd_rst = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check_reset_regs("lcd_rst");
      @(posedge clk);
      #1;
      lcd_rst = 1'b1;
      repeat (4) @(posedge clk);
      exp_q.push_back({9'd0, 8'h77});
      exp_bv++;
      send_byte(8'h77, 1'b1);
      repeat (3) @(posedge clk);
      drain_writes();
      check("lcd_rst_bv_count", 32'(n_bv), 32'(exp_bv));
      check("lcd_rst_missing_writes", 32'(exp_q.size()), 32'd0);
      check("lcd_rst_power_down", 32'(power_down), 32'd1);
      raise_sce();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pcd8544_spi_rx.md
Name: pcd8544_spi_rx

Overview:
- Device-side receiver for the Nokia 5110 / PCD8544 serial link that our SPI master drives: pins sclk, mosi, sce, dc and lcd_rst.
- Oversamples the link in the system clock domain, deserialises bytes MSB-first and decodes them as PCD8544 commands (dc=0) or display-RAM data (dc=1).
- Produces a framebuffer write port plus the controller's status registers.
- Used as the LCD model in benches and as the front end of an on-board display mirror (e.g. VGA).

Parameters:
COLS, 84, display columns (X range 0..COLS-1)
ROWS, 6, display banks (Y range 0..ROWS-1)
SYNC_STAGES, 2, synchroniser flops per input pin (minimum 2)
AW, 9, framebuffer address width; must satisfy 2^AW >= COLS*ROWS

Ports:
clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
sclk  in  1  SPI clock from master; data sampled on rising edge
mosi  in  1  serial data, MSB first
sce  in  1  chip enable, active-low
dc  in  1  0 = command, 1 = data; sampled with bit 0
lcd_rst  in  1  display reset pin, active-low
wr_en  out  1  one-cycle framebuffer write strobe
wr_addr  out  AW  Y*COLS+X of the write
wr_data  out  8  data byte (bit0 = top pixel of the bank)
byte_valid  out  1  one-cycle pulse per received byte (command or data)
power_down  out  1  PD bit
v_addr  out  1  V bit (1 = vertical addressing)
ext_instr  out  1  H bit (1 = extended instruction set)
disp_mode  out  2  {D,E}: 00 blank, 10 normal, 01 all on, 11 inverse
vop  out  7  contrast setting
bias  out  3  bias setting
tc  out  2  temperature coefficient

Behaviour:
- Reset low (asynchronous): all outputs and state 0, except power_down=1. X=0, Y=0, bit counter=0.
- Synchronised lcd_rst low: same register values as Reset, applied synchronously. No decode and no wr_en while it stays low.
- Inputs pass through SYNC_STAGES flops. A sclk rising edge is detected from the last two sync stages.
- Supported SCLK: at most clock/4. Faster SCLK is unsupported; no behaviour is defined for it.
- Per detected edge with synced sce=0: shift in mosi and increment the 3-bit counter. On the 8th bit, latch byte={shift,mosi} and dc.
- Synced sce=1: counter cleared and partial byte discarded. An edge in the same cycle as sce sampled high is ignored.
- Latency: byte_valid, wr_en and any register update occur exactly 1 cycle after the cycle that detected the 8th edge.
- States: IDLE (sce high) -> SHIFT (sce low, counting) -> DECODE (1 cycle) -> SHIFT (sce still low) or IDLE.
- Back-to-back bytes with sce held low are supported.
- Data byte (dc=1): wr_en=1, wr_addr=Y*COLS+X, wr_data=byte, then advance the address pointer:
  - V=0: X++. At X=COLS-1, X=0 and Y++. At Y=ROWS-1, Y=0.
  - V=1: Y++. At Y=ROWS-1, Y=0 and X++. At X=COLS-1, X=0.
  - Last cell (X=COLS-1, Y=ROWS-1) wraps to (0,0) in both modes.
- Command byte (dc=0), decoded by priority:
  - 0x00: NOP.
  - 00100PVH (function set, valid in either H): sets power_down, v_addr, ext_instr.
  - H=0, 00001D0E: disp_mode={D,E}.
  - H=0, 01000YYY: Y=YYY if YYY<ROWS, otherwise ignored.
  - H=0, 1XXXXXXX: X=value if <COLS, otherwise ignored.
  - H=1, 000001TT: tc.
  - H=1, 00010BBB: bias.
  - H=1, 1VVVVVVV: vop.
  - Any other pattern: ignored, byte_valid still pulses.
- Address arithmetic: X 7 bits, Y 3 bits. wr_addr is computed in AW bits without truncation for the default parameters.
- A function set takes effect for the immediately following byte.

Decomposition:
- Shared package pcd8544_pkg: opcode masks/values (FUNC_SET, DISP_CTRL, SET_Y, SET_X, TEMP_CTRL, BIAS, VOP), disp_mode encodings, COLS/ROWS defaults.
- One sub-module: spi_byte_deserializer (synchronisers, edge detect, bit counter, byte + dc strobe).
- Command decode and address pointer stay in the top level.

Test Plan:
- Init sequence 0x21, 0x90, 0x20, 0x0C (dc=0) -> ext_instr 1 then 0, vop=0x10, disp_mode=2'b10, power_down=0, four byte_valid pulses, no wr_en.
- 0xA1, 0x42 (dc=0) then 0xFE, 0x81 (dc=1) -> X=33, Y=2; writes addr 201 data 0xFE, then addr 202 data 0x81.
- 0xD3 (X=83), 0x45 (Y=5), data 0x55, 0xAA -> writes at addr 503 then addr 0.
- 0x22 (V=1), X=0, Y=5, data 0x11, 0x22 -> writes at addr 420 then addr 1 (X=1, Y=0).
- 5 bits clocked, sce high, sce low, full byte 0x3C dc=1 -> exactly one write with data 0x3C.
- Out-of-range 0xD4 and 0x46 -> X/Y unchanged. Pulse lcd_rst low mid-byte -> registers at reset values, partial byte discarded, no wr_en.
